// File: rtl/stream_select_mux.sv
// Routes one of NUM_SELECT input streams to a single registered output for one packet.
// Each packet needs a (select, type) config pair that both handshake together.
module stream_select_mux #(
  parameter int NUM_SELECT   = 4,
  parameter int DATA_WIDTH   = 512,
  parameter int TYPE_WIDTH   = 4,
  parameter int SELECT_WIDTH = $clog2(NUM_SELECT)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             cfg_select_valid,
  output logic                             cfg_select_ready,
  input  logic [SELECT_WIDTH-1:0]          cfg_select_data,
  input  logic                             cfg_type_valid,
  output logic                             cfg_type_ready,
  input  logic [TYPE_WIDTH-1:0]            cfg_type_data,
  input  logic [NUM_SELECT-1:0]            in_valid,
  output logic [NUM_SELECT-1:0]            in_ready,
  input  logic [NUM_SELECT*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_SELECT-1:0]            in_last,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic                             out_last,
  output logic [TYPE_WIDTH-1:0]            out_type,
  output logic [31:0]                      packet_count,
  output logic                             sel_error
);

  typedef enum logic {IDLE, ACTIVE} state_e;

  state_e                  state_q, state_d;
  logic [SELECT_WIDTH-1:0] sel_q, sel_d;
  logic [TYPE_WIDTH-1:0]   type_q, type_d;
  logic                    out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
  logic                    out_last_q, out_last_d;
  logic [TYPE_WIDTH-1:0]   out_type_q, out_type_d;
  logic [31:0]             packet_count_q, packet_count_d;
  logic                    sel_error_q, sel_error_d;

  logic                    cfg_join;
  logic                    sel_in_range;
  logic                    beat_ready;
  logic                    beat_fire;
  logic [DATA_WIDTH-1:0]   sel_beat;

  always_comb begin
    cfg_join     = (state_q == IDLE) && cfg_select_valid && cfg_type_valid;
    sel_in_range = 32'(cfg_select_data) < NUM_SELECT;
    // The output register only takes a new beat when empty or draining this cycle.
    beat_ready   = (state_q == ACTIVE) && (!out_valid_q || out_ready);
    in_ready     = '0;
    if (beat_ready) in_ready[sel_q] = 1'b1;
    beat_fire    = beat_ready && in_valid[sel_q];
    sel_beat     = in_data[int'(sel_q)*DATA_WIDTH +: DATA_WIDTH];

    state_d        = state_q;
    sel_d          = sel_q;
    type_d         = type_q;
    packet_count_d = packet_count_q;
    sel_error_d    = sel_error_q;
    out_valid_d    = out_valid_q;
    out_data_d     = out_data_q;
    out_last_d     = out_last_q;
    out_type_d     = out_type_q;

    case (state_q)
      IDLE: begin
        if (cfg_join) begin
          if (sel_in_range) begin
            sel_d   = cfg_select_data;
            type_d  = cfg_type_data;
            state_d = ACTIVE;
          end else begin
            sel_error_d = 1'b1;
          end
        end
      end
      ACTIVE: begin
        if (beat_fire && in_last[sel_q]) begin
          state_d        = IDLE;
          packet_count_d = packet_count_q + 32'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (beat_fire) begin
      out_valid_d = 1'b1;
      out_data_d  = sel_beat;
      out_last_d  = in_last[sel_q];
      out_type_d  = type_q;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      sel_q          <= '0;
      type_q         <= '0;
      packet_count_q <= '0;
      sel_error_q    <= 1'b0;
      out_valid_q    <= 1'b0;
      out_data_q     <= '0;
      out_last_q     <= 1'b0;
      out_type_q     <= '0;
    end else begin
      state_q        <= state_d;
      sel_q          <= sel_d;
      type_q         <= type_d;
      packet_count_q <= packet_count_d;
      sel_error_q    <= sel_error_d;
      out_valid_q    <= out_valid_d;
      out_data_q     <= out_data_d;
      out_last_q     <= out_last_d;
      out_type_q     <= out_type_d;
    end
  end

  assign cfg_select_ready = cfg_join;
  assign cfg_type_ready   = cfg_join;
  assign out_valid        = out_valid_q;
  assign out_data         = out_data_q;
  assign out_last         = out_last_q;
  assign out_type         = out_type_q;
  assign packet_count     = packet_count_q;
  assign sel_error        = sel_error_q;

endmodule

// File: doc/stream_select_mux.md
Name: stream_select_mux

Overview:
- Consumer end of the per-stream configuration channel produced by the stream configuration register block.
- Accepts a (select, data_type) configuration pair through two ready/valid channels.
- Routes one of NUM_SELECT input data streams to a single output stream, tagging every beat with the configured data type, until the end of one packet (`last` beat).
- Sits between the config register file and the operator pipeline; one instance per output stream.

Parameters:
- NUM_SELECT, 4, number of selectable input streams (>= 2).
- DATA_WIDTH, 512, data beat width in bits.
- TYPE_WIDTH, 4, width of the data type tag.
- SELECT_WIDTH, $clog2(NUM_SELECT), derived; not overridden.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous active-low reset.
- cfg_select_valid  in  1  select config valid.
- cfg_select_ready  out  1  select config accepted.
- cfg_select_data  in  SELECT_WIDTH  input stream index.
- cfg_type_valid  in  1  type config valid.
- cfg_type_ready  out  1  type config accepted.
- cfg_type_data  in  TYPE_WIDTH  data type tag for the packet.
- in_valid  in  NUM_SELECT  per-input beat valid.
- in_ready  out  NUM_SELECT  per-input beat ready.
- in_data  in  NUM_SELECT*DATA_WIDTH  packed input beats; input i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- in_last  in  NUM_SELECT  per-input end-of-packet.
- out_valid  out  1  output beat valid (registered).
- out_ready  in  1  downstream ready.
- out_data  out  DATA_WIDTH  output beat.
- out_last  out  1  output end-of-packet.
- out_type  out  TYPE_WIDTH  data type of current output beat.
- packet_count  out  32  packets forwarded; wraps at 2^32.
- sel_error  out  1  sticky flag: out-of-range select received.

Behaviour:
- Reset (async assert, sync deassert assumed upstream):
  - state=IDLE; out_valid=0, out_last=0, out_data=0, out_type=0.
  - packet_count=0, sel_error=0; latched select/type=0.
- FSM states: IDLE, ACTIVE.
- IDLE, config join:
  - cfg_select_ready = cfg_type_ready = (cfg_select_valid && cfg_type_valid). Both handshakes complete in the same cycle; neither is consumed alone.
  - On the join, if cfg_select_data < NUM_SELECT: latch select and type, go to ACTIVE next cycle.
  - Otherwise: set sel_error (sticky until reset), discard the pair, stay IDLE.
  - In IDLE, in_ready = 0 for all inputs.
- ACTIVE:
  - cfg_*_ready = 0.
  - in_ready[sel] = !out_valid || out_ready; all other in_ready bits = 0.
  - On an accepted beat (in_valid[sel] && in_ready[sel]), next cycle: out_valid=1, out_data=in_data[sel], out_last=in_last[sel], out_type=latched type.
  - If the accepted beat has in_last=1: state goes to IDLE next cycle and packet_count increments in the same cycle.
- Output register:
  - Cleared to out_valid=0 when out_ready && out_valid and no new beat is accepted.
  - Full throughput: 1 beat/cycle; latency 1 cycle from input acceptance to out_valid.
  - Output register contents hold stable while out_valid && !out_ready.
- Packet boundary:
  - A new config may join in IDLE while the previous last beat still sits in the output register; ordering is preserved because the register stalls new input.
  - Minimum gap between packets is 1 cycle (the IDLE cycle for the config join).
- Single-beat packet (in_last=1 on first beat): ACTIVE lasts exactly one accepting cycle.
- Out-of-range select values (NUM_SELECT not a power of two) never reach ACTIVE; the selected index is always in range.
- Reset mid-packet: all state cleared immediately; a partial packet is dropped; no further in_ready until a new config.
- packet_count wraps from 0xFFFFFFFF to 0.

Test Plan:
- Reset, then config (select=2, type=5) with input 2 sending 3 beats (D0, D1, D2, last on D2), out_ready=1 -> out beats D0, D1, D2 one cycle after each input, out_type=5, out_last only on D2; packet_count=1; in_ready[0,1,3]=0 throughout.
- Config valid on select only (type channel idle) for 10 cycles -> cfg_select_ready stays 0; assert type valid -> both ready in the same cycle, ACTIVE next cycle.
- Backpressure: out_ready toggling 1/0 every cycle during a 4-beat packet -> no beat lost or duplicated; out_data stable while stalled.
- Back-to-back packets: select=0 then select=1, each a single beat -> 2 output beats in order with correct types; packet_count=2; one IDLE cycle between packets.
- NUM_SELECT=3, config select=3 -> sel_error=1, no in_ready asserted; next valid config (select=1) routes normally and sel_error stays 1.
- Assert rst_n=0 mid-packet after 2 of 5 beats -> outputs and counters go to reset values immediately; after release, in_ready=0 until a new config.
